// File: rtl/booth_pkg.sv
// booth_pkg: shared state/digit types and the radix-4 Booth window decoder.
package booth_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    typedef enum logic [2:0] {ZERO, P1, P2, N1, N2} digit_e;

    function automatic digit_e booth_decode(input logic [2:0] w);
        case (w)
            3'b001, 3'b010: return P1;
            3'b011:         return P2;
            3'b100:         return N2;
            3'b101, 3'b110: return N1;
            default:        return ZERO;
        endcase
    endfunction

endpackage

// File: rtl/booth_r4_step.sv
// booth_r4_step: one combinational radix-4 Booth step (add digit*M, then arithmetic shift right by 2).
module booth_r4_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] m_i,
    input  logic [WIDTH+1:0] a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             qm1_i,
    output logic [WIDTH+1:0] a_o,
    output logic [WIDTH-1:0] q_o,
    output logic             qm1_o
);

    logic [WIDTH+1:0]        m_ext, m_x2, addend, sum;
    logic signed [2*WIDTH+2:0] cat, sh;
    digit_e                  digit;

    // Two guard bits keep A exact even for +/-2M of the most negative operand.
    assign m_ext  = {{2{m_i[WIDTH-1]}}, m_i};
    assign m_x2   = m_ext << 1;
    assign digit  = booth_decode({q_i[1:0], qm1_i});
    assign addend = digit == P1 ? m_ext :
                    digit == P2 ? m_x2 :
                    digit == N1 ? -m_ext :
                    digit == N2 ? -m_x2 : '0;
    assign sum    = a_i + addend;
    assign cat    = {sum, q_i, qm1_i};
    assign sh     = cat >>> 2;
    assign a_o    = sh[2*WIDTH+2:WIDTH+1];
    assign q_o    = sh[WIDTH:1];
    assign qm1_o  = sh[0];

endmodule

// File: rtl/booth_r4_seq_ctrl.sv
// booth_r4_seq_ctrl: iterative radix-4 Booth multiplier, one shared step per cycle,
// with valid/ready handshakes on operands and product plus a synchronous abort.
module booth_r4_seq_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     m_i,
    input  logic [WIDTH-1:0]     q_i,
    input  logic                 abort_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   product_o,
    output logic                 busy_o
);

    localparam int            CW   = $clog2(WIDTH / 2) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
        $error("booth_r4_seq_ctrl: WIDTH must be even and >= 4");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   m_q, qr_q, qr_d;
    logic [WIDTH+1:0]   a_q, a_d;
    logic               qm1_q, qm1_d;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] prod_q;
    logic               accept, step, last;

    booth_r4_step #(.WIDTH(WIDTH)) u_step (
        .m_i   (m_q),
        .a_i   (a_q),
        .q_i   (qr_q),
        .qm1_i (qm1_q),
        .a_o   (a_d),
        .q_o   (qr_d),
        .qm1_o (qm1_d)
    );

    assign accept = state_q == IDLE && in_valid_i && !abort_i;
    assign step   = state_q == RUN && !abort_i;
    assign last   = cnt_q == LAST;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? RUN : IDLE;
            RUN:     state_d = abort_i ? IDLE : (last ? DONE : RUN);
            DONE:    state_d = (out_ready_i || abort_i) ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready_o  = state_q == IDLE;
    assign out_valid_o = state_q == DONE;
    assign busy_o      = state_q != IDLE;
    assign product_o   = prod_q;

    // The product register only updates on the final step, so an abort leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            a_q     <= '0;
            qr_q    <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                m_q   <= m_i;
                a_q   <= '0;
                qr_q  <= q_i;
                qm1_q <= 1'b0;
                cnt_q <= '0;
            end else if (step) begin
                a_q   <= a_d;
                qr_q  <= qr_d;
                qm1_q <= qm1_d;
                cnt_q <= cnt_q + CW'(1);
                if (last) prod_q <= {a_d[WIDTH-1:0], qr_d};
            end
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_ctrl.sv
// tb_booth_r4_seq_ctrl: directed self-checking bench for an 8-bit and a 4-bit instance.
module tb_booth_r4_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        iv8 = 1'b0, ir8, ab8 = 1'b0, ov8, or8 = 1'b1, b8;
    logic [7:0]  m8 = '0, q8 = '0;
    logic [15:0] p8;

    logic        iv4 = 1'b0, ir4, ab4 = 1'b0, ov4, or4 = 1'b1, b4;
    logic [3:0]  m4 = '0, q4 = '0;
    logic [7:0]  p4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_r4_seq_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(iv8), .in_ready_o(ir8), .m_i(m8), .q_i(q8),
        .abort_i(ab8), .out_valid_o(ov8), .out_ready_i(or8), .product_o(p8), .busy_o(b8)
    );

    booth_r4_seq_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(iv4), .in_ready_o(ir4), .m_i(m4), .q_i(q4),
        .abort_i(ab4), .out_valid_o(ov4), .out_ready_i(or4), .product_o(p4), .busy_o(b4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one 8-bit op with out_ready=1; returns at the negedge where out_valid is seen.
    task automatic mul8(input int m, input int q, output logic [15:0] p, output int lat);
        @(negedge clk);
        iv8 = 1'b1; m8 = m[7:0]; q8 = q[7:0]; or8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        p = p8;
    endtask

    initial begin
        logic [15:0]       p;
        int                lat, k, e;
        logic signed [3:0] ms, qs;

        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'b0, ir8}, 32'd1);
        check("rst_out_valid", {31'b0, ov8}, 32'd0);
        check("rst_busy", {31'b0, b8}, 32'd0);
        check("rst_product", {16'b0, p8}, 32'd0);
        rst_n = 1'b1;

        mul8(7, 3, p, lat);
        check("t1_product", {16'b0, p}, 32'h0015);
        check("t1_latency", lat, 32'd5);
        check("t1_out_valid", {31'b0, ov8}, 32'd1);

        mul8(-128, -128, p, lat);
        check("t2_minmin", {16'b0, p}, 32'h4000);
        mul8(-128, 127, p, lat);
        check("t2_min_max", {16'b0, p}, 32'hC080);
        mul8(0, -1, p, lat);
        check("t2_zero", {16'b0, p}, 32'h0000);

        @(negedge clk);
        or8 = 1'b0; iv8 = 1'b1; m8 = 8'd11; q8 = 8'hFA;
        @(negedge clk);
        iv8 = 1'b0;
        k = 0;
        while (!ov8 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t3_product", {16'b0, p8}, 32'hFFBE);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            iv8 = i[0]; m8 = 8'd1; q8 = 8'd1;
            check("t3_hold_valid", {31'b0, ov8}, 32'd1);
            check("t3_hold_product", {16'b0, p8}, 32'hFFBE);
            check("t3_hold_in_ready", {31'b0, ir8}, 32'd0);
        end
        iv8 = 1'b0; or8 = 1'b1;
        @(negedge clk);
        check("t3_idle_valid", {31'b0, ov8}, 32'd0);
        check("t3_idle_in_ready", {31'b0, ir8}, 32'd1);
        check("t3_idle_busy", {31'b0, b8}, 32'd0);

        @(negedge clk);
        iv8 = 1'b1; m8 = 8'd5; q8 = 8'd9;
        @(negedge clk);
        iv8 = 1'b0;
        @(negedge clk);
        check("t4_busy_run", {31'b0, b8}, 32'd1);
        ab8 = 1'b1;
        @(negedge clk);
        ab8 = 1'b0;
        check("t4_abort_in_ready", {31'b0, ir8}, 32'd1);
        check("t4_abort_busy", {31'b0, b8}, 32'd0);
        check("t4_abort_product", {16'b0, p8}, 32'hFFBE);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t4_no_valid", {31'b0, ov8}, 32'd0);
        end
        mul8(-3, 4, p, lat);
        check("t4_next_op", {16'b0, p}, 32'hFFF4);

        @(negedge clk);
        iv8 = 1'b1; m8 = 8'd9; q8 = 8'd9;
        @(negedge clk);
        iv8 = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_in_ready", {31'b0, ir8}, 32'd1);
        check("t5_out_valid", {31'b0, ov8}, 32'd0);
        check("t5_busy", {31'b0, b8}, 32'd0);
        check("t5_product", {16'b0, p8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mul8(-1, -1, p, lat);
        check("t5_after", {16'b0, p}, 32'h0001);
        check("t5_latency", lat, 32'd5);

        @(negedge clk);
        iv4 = 1'b1; or4 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            m4 = i[7:4]; q4 = i[3:0];
            ms = i[7:4]; qs = i[3:0];
            e = int'(ms) * int'(qs);
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!ov4 && k < 10);
            check("t6_product", {24'b0, p4}, {24'b0, e[7:0]});
            check("t6_spacing", k, (i == 0) ? 32'd3 : 32'd4);
        end
        iv4 = 1'b0;
        @(negedge clk);
        check("t6_idle_busy", {31'b0, b4}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
